// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared types for the pipeline hazard controller.
//   sb_entry_t  : one scoreboard slot describing an in-flight register writer
//   FWD_REGFILE : forward-select code meaning "use ID/EX register data"
// Scoreboard entries hold destination addresses zero-extended to SB_RD_W bits,
// so any REG_AW up to SB_RD_W is supported.
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

  localparam int SB_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of in-flight writers plus a youngest-match priority encoder
// for two source operands.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   issue_i           ID instruction advances into EX this edge
//   rd_addr_i/rd_we_i destination of the ID instruction
//   is_load_i         ID instruction is a load
//   src_a/b_addr_i    source register addresses being checked
//   hit_*_o           some in-flight writer matches the source
//   pos_*_o           k+1 of the youngest matching entry k
//   load_*_o          the youngest matching entry is a load
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_we_i,
  input  logic              is_load_i,
  input  logic [REG_AW-1:0] src_a_addr_i,
  input  logic [REG_AW-1:0] src_b_addr_i,
  output logic              hit_a_o,
  output logic [SELW-1:0]   pos_a_o,
  output logic              load_a_o,
  output logic              hit_b_o,
  output logic [SELW-1:0]   pos_b_o,
  output logic              load_b_o
);

  sb_entry_t              sb_w [FWD_DEPTH];
  sb_entry_t              ent0_d;
  logic [FWD_DEPTH-1:0]   match_a;
  logic [FWD_DEPTH-1:0]   match_b;
  logic [SB_RD_W-1:0]     src_a_ext;
  logic [SB_RD_W-1:0]     src_b_ext;

  assign src_a_ext = SB_RD_W'(src_a_addr_i);
  assign src_b_ext = SB_RD_W'(src_b_addr_i);

  // Writers of x0 and non-writers never occupy a slot, so x0 can never match.
  always_comb begin
    ent0_d = '0;
    if (issue_i && rd_we_i && (rd_addr_i != '0)) begin
      ent0_d.valid   = 1'b1;
      ent0_d.rd      = SB_RD_W'(rd_addr_i);
      ent0_d.is_load = is_load_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_sb
      sb_entry_t ent_q;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) ent_q <= '0;
          else     ent_q <= ent0_d;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) ent_q <= '0;
          else     ent_q <= sb_w[gi-1];
        end
      end

      assign sb_w[gi]    = ent_q;
      assign match_a[gi] = ent_q.valid && (ent_q.rd == src_a_ext);
      assign match_b[gi] = ent_q.valid && (ent_q.rd == src_b_ext);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching k is left standing.
  always_comb begin
    hit_a_o  = 1'b0;
    pos_a_o  = '0;
    load_a_o = 1'b0;
    hit_b_o  = 1'b0;
    pos_b_o  = '0;
    load_b_o = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        hit_a_o  = 1'b1;
        pos_a_o  = SELW'(k + 1);
        load_a_o = sb_w[k].is_load;
      end
      if (match_b[k]) begin
        hit_b_o  = 1'b1;
        pos_b_o  = SELW'(k + 1);
        load_b_o = sb_w[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller sitting beside the ID-stage decoder: load-use
// interlock, EX operand forward selection and redirect flush sequencing.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1/rs2_addr, _used    ID source operands and whether they are read
//   id_rd_addr, id_rd_we      ID destination and write enable
//   id_is_load                ID instruction is a load
//   id_redirect               jump / taken branch resolved in ID
//   stall                     hold PC and IF/ID, bubble into ID/EX
//   flush_id                  IF/ID loads a NOP at this edge
//   fwd_sel_a/b               EX operand source (0 = ID/EX data, j = position j)
// Build option HAZARD_PERF_EN adds perf_stall_cnt / perf_flush_cnt, saturating
// counts of cycles with stall and flush_id asserted.
// -----------------------------------------------------------------------------
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int FWD_DEPTH      = 2,
  parameter int LOAD_LAT       = 2,
  parameter int BRANCH_PENALTY = 2,
  parameter int SELW           = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_redirect,
  output logic              stall,
  output logic              flush_id,
  output logic [SELW-1:0]   fwd_sel_a,
  output logic [SELW-1:0]   fwd_sel_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CNTW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;

  logic            hit_a, hit_b, load_a, load_b;
  logic [SELW-1:0] pos_a, pos_b;
  logic            src_a_live, src_b_live;
  logic            stall_a, stall_b, stall_raw;
  logic            issue;
  logic            redirect_fire;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
  logic [SELW-1:0] fwd_a_q, fwd_a_d;
  logic [SELW-1:0] fwd_b_q, fwd_b_d;

  assign src_a_live = id_rs1_used && (id_rs1_addr != '0);
  assign src_b_live = id_rs2_used && (id_rs2_addr != '0);

  // A load at position pos delivers data only from LOAD_LAT onward.
  assign stall_a   = src_a_live && hit_a && load_a && (int'(pos_a) < LOAD_LAT);
  assign stall_b   = src_b_live && hit_b && load_b && (int'(pos_b) < LOAD_LAT);
  assign stall_raw = id_valid && (stall_a || stall_b);
  assign issue     = id_valid && !stall_raw;

  // A redirect only counts when its instruction actually leaves ID, so a
  // stalled branch is naturally re-presented and fires once the stall clears.
  assign redirect_fire = id_redirect && issue && (flush_cnt_q == '0);

  assign stall    = !rst && stall_raw;
  assign flush_id = !rst && (redirect_fire || (flush_cnt_q != '0));

  hazard_scoreboard #(
    .REG_AW    (REG_AW),
    .FWD_DEPTH (FWD_DEPTH),
    .SELW      (SELW)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue),
    .rd_addr_i    (id_rd_addr),
    .rd_we_i      (id_rd_we),
    .is_load_i    (id_is_load),
    .src_a_addr_i (id_rs1_addr),
    .src_b_addr_i (id_rs2_addr),
    .hit_a_o      (hit_a),
    .pos_a_o      (pos_a),
    .load_a_o     (load_a),
    .hit_b_o      (hit_b),
    .pos_b_o      (pos_b),
    .load_b_o     (load_b)
  );

  // Writers older than the scoreboard have already reached the regfile, whose
  // write-through covers them, so a miss selects the ID/EX register data.
  always_comb begin
    fwd_a_d = SELW'(FWD_REGFILE);
    fwd_b_d = SELW'(FWD_REGFILE);
    if (issue && src_a_live && hit_a) fwd_a_d = pos_a;
    if (issue && src_b_live && hit_b) fwd_b_d = pos_b;
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect_fire)
      flush_cnt_d = CNTW'(BRANCH_PENALTY - 1);
    else if (flush_cnt_q != '0)
      flush_cnt_d = flush_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (flush_id && (perf_flush_q != 32'hFFFF_FFFF))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Two instances: unit 0 with default parameters (FWD_DEPTH=2, LOAD_LAT=2,
// BRANCH_PENALTY=2) and unit 1 with FWD_DEPTH=3, LOAD_LAT=1, BRANCH_PENALTY=3.
// The driver applies one directed instruction per cycle to the selected unit
// and queues the hand-computed outputs for that cycle; the monitor pops and
// compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       v_in   [2];
  logic [4:0] rs1_in [2];
  logic [4:0] rs2_in [2];
  logic       u1_in  [2];
  logic       u2_in  [2];
  logic [4:0] rd_in  [2];
  logic       we_in  [2];
  logic       ld_in  [2];
  logic       rdr_in [2];
  logic       st_o   [2];
  logic       fl_o   [2];
  logic [1:0] fa_o   [2];
  logic [1:0] fb_o   [2];
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_s [2];
  logic [31:0] perf_f [2];
`endif

  typedef struct {
    int   id;
    bit   u;
    logic st;
    logic fl;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_id   = 0;

  always #5 clk = ~clk;

  hazard_unit u_dut0 (
    .clk(clk), .rst(rst), .id_valid(v_in[0]),
    .id_rs1_addr(rs1_in[0]), .id_rs2_addr(rs2_in[0]),
    .id_rs1_used(u1_in[0]), .id_rs2_used(u2_in[0]),
    .id_rd_addr(rd_in[0]), .id_rd_we(we_in[0]), .id_is_load(ld_in[0]),
    .id_redirect(rdr_in[0]),
    .stall(st_o[0]), .flush_id(fl_o[0]),
    .fwd_sel_a(fa_o[0]), .fwd_sel_b(fb_o[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_s[0]), .perf_flush_cnt(perf_f[0])
`endif
  );

  hazard_unit #(
    .FWD_DEPTH(3), .LOAD_LAT(1), .BRANCH_PENALTY(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(v_in[1]),
    .id_rs1_addr(rs1_in[1]), .id_rs2_addr(rs2_in[1]),
    .id_rs1_used(u1_in[1]), .id_rs2_used(u2_in[1]),
    .id_rd_addr(rd_in[1]), .id_rd_we(we_in[1]), .id_is_load(ld_in[1]),
    .id_redirect(rdr_in[1]),
    .stall(st_o[1]), .flush_id(fl_o[1]),
    .fwd_sel_a(fa_o[1]), .fwd_sel_b(fb_o[1])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_s[1]), .perf_flush_cnt(perf_f[1])
`endif
  );

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      v_in[i[0]]   = 1'b0; rs1_in[i[0]] = '0; rs2_in[i[0]] = '0;
      u1_in[i[0]]  = 1'b0; u2_in[i[0]]  = 1'b0; rd_in[i[0]]  = '0;
      we_in[i[0]]  = 1'b0; ld_in[i[0]]  = 1'b0; rdr_in[i[0]] = 1'b0;
    end
  endtask

  // One ID-stage cycle on unit u, followed by the outputs expected this cycle.
  task automatic drive(input bit u, input logic v,
                       input int rs1, input logic u1, input int rs2, input logic u2,
                       input int rd, input logic we, input logic ld, input logic rdr,
                       input logic est, input logic efl, input int efa, input int efb);
    exp_t e;
    idle_all();
    v_in[u]   = v;
    rs1_in[u] = rs1[4:0];
    u1_in[u]  = u1;
    rs2_in[u] = rs2[4:0];
    u2_in[u]  = u2;
    rd_in[u]  = rd[4:0];
    we_in[u]  = we;
    ld_in[u]  = ld;
    rdr_in[u] = rdr;
    row_id++;
    e.id = row_id; e.u = u; e.st = est; e.fl = efl;
    e.fa = efa[1:0]; e.fb = efb[1:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input bit u, input logic est, input logic efl,
                     input int efa, input int efb);
    drive(u, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, est, efl, efa, efb);
  endtask

  task automatic reset_cycle();
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check(input string name, input int id,
                       input logic [1:0] act, input logic [1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, id, act, expv);
    end
  endtask

  // Monitor: every cycle that has a queued expectation is compared here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",     e.id, {1'b0, st_o[e.u]}, {1'b0, e.st});
        check("flush_id",  e.id, {1'b0, fl_o[e.u]}, {1'b0, e.fl});
        check("fwd_sel_a", e.id, fa_o[e.u], e.fa);
        check("fwd_sel_b", e.id, fb_o[e.u], e.fb);
        $display("row %0d unit %0d: stall=%0d flush=%0d fa=%0d fb=%0d",
                 e.id, e.u, st_o[e.u], fl_o[e.u], fa_o[e.u], fb_o[e.u]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state on both units
    nop(1'b0, 0, 0, 0, 0);
    nop(1'b1, 0, 0, 0, 0);

    // 1: add x5,x1,x2 ; sub x6,x5,x1 -> fa=1 in sub's EX
    drive(1'b0, 1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 5, 1, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 1, 0);
    // 2: add x5 ; nop ; or x7,x1,x5 -> fb=2
    drive(1'b0, 1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 0);
    drive(1'b0, 1, 1, 1, 5, 1, 7, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 2);
    //    distance 3 -> fb=0
    drive(1'b0, 1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 0);
    drive(1'b0, 1, 1, 1, 5, 1, 7, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 0);
    // 3: lw x7 ; add x8,x7,x7 -> one stall cycle, then fa=fb=2
    drive(1'b0, 1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 7, 1, 7, 1, 8, 1, 0, 0,  1, 0, 0, 0);
    drive(1'b0, 1, 7, 1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 2, 2);
    // 4: write to x0, non-writer of x3, then reader of x0 and x3
    drive(1'b0, 1, 1, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 1, 1, 2, 1, 3, 0, 0, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 0, 1, 3, 1, 10, 1, 0, 0, 0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 0);
    // 5: lw x5 ; addi x5,x1 ; add x11,x5,x5 -> youngest (position 1) wins
    drive(1'b0, 1, 1, 1, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 1, 1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 5, 1, 5, 1, 11, 1, 0, 0, 0, 0, 0, 0);
    nop(1'b0, 0, 0, 1, 1);
    // 6: jal -> two flush edges
    drive(1'b0, 1, 0, 0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 0);
    nop(1'b0, 0, 1, 0, 0);
    nop(1'b0, 0, 0, 0, 0);
    //    lw x7 ; beq x7,x0 taken -> stall first, redirect fires after
    drive(1'b0, 1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 7, 1, 0, 1, 0, 0, 0, 1,  1, 0, 0, 0);
    drive(1'b0, 1, 7, 1, 0, 1, 0, 0, 0, 1,  0, 1, 0, 0);
    nop(1'b0, 0, 1, 2, 0);
    nop(1'b0, 0, 0, 0, 0);
    //    reset mid-flush
    drive(1'b0, 1, 0, 0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 0);
    reset_cycle();
    nop(1'b0, 0, 0, 0, 0);
    //    reset mid-stall clears the pending load
    drive(1'b0, 1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);
    drive(1'b0, 1, 7, 1, 7, 1, 8, 1, 0, 0,  1, 0, 0, 0);
    reset_cycle();
    drive(1'b0, 1, 7, 1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b0, 0, 0, 0, 0);

    // Unit 1: LOAD_LAT=1 -> no stall, fwd=1
    drive(1'b1, 1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);
    drive(1'b1, 1, 7, 1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b1, 0, 0, 1, 1);
    //   FWD_DEPTH=3 reaches distance 3
    nop(1'b1, 0, 0, 0, 0);
    drive(1'b1, 1, 1, 1, 8, 1, 9, 1, 0, 0,  0, 0, 0, 0);
    nop(1'b1, 0, 0, 0, 3);
    //   BRANCH_PENALTY=3 -> three flush edges
    drive(1'b1, 1, 0, 0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 0);
    nop(1'b1, 0, 1, 0, 0);
    nop(1'b1, 0, 1, 0, 0);
    nop(1'b1, 0, 0, 0, 0);

    idle_all();
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised pipeline hazard controller for the in-order RV32E core and its deeper successors. It replaces the fixed two-source forwarding check and the hard-wired two-cycle branch flush with four generalised behaviours:
- a shift-register scoreboard of in-flight writers;
- forward-source selection over N downstream stages;
- load-use interlock for configurable load latency;
- a configurable redirect flush counter.

It sits beside the decoder in ID and drives the IF/ID, ID/EX enables and the EX operand muxes.

Parameters:
REG_AW, 5, register address width.
FWD_DEPTH, 2, number of downstream forwarding positions (1 = MEM, 2 = WB, ...), ≥1.
LOAD_LAT, 2, first downstream position at which load data is valid, 1..FWD_DEPTH.
BRANCH_PENALTY, 2, consecutive IF/ID flush edges per redirect, ≥1.
SELW, $clog2(FWD_DEPTH+1), forward select width (derived).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real (non-NOP) instruction
id_rs1_addr  in  REG_AW  rs1 of ID instruction
id_rs2_addr  in  REG_AW  rs2 of ID instruction
id_rs1_used  in  1  rs1 is read
id_rs2_used  in  1  rs2 is read
id_rd_addr  in  REG_AW  destination
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_redirect  in  1  jump or taken branch resolved in ID
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush_id  out  1  IF/ID loads NOP at this edge
fwd_sel_a  out  SELW  EX operand A source: 0 = ID/EX register data, j = position j
fwd_sel_b  out  SELW  EX operand B source, same encoding

Behaviour:
- Scoreboard:
  - FWD_DEPTH entries {valid, rd, is_load}. Entry k is the instruction k+1 positions past ID (entry 0 = EX).
  - Shifts every cycle; the oldest entry drops out.
  - Entry 0 loads the ID instruction when issue = id_valid & !stall. Otherwise entry 0 loads an invalid bubble.
  - An entry is valid only if id_rd_we=1 and rd≠0.
- Match rule, per used source:
  - Entry k matches if valid and rd equals the source address.
  - Pick the youngest match (lowest k).
  - The producer will be at position k+1 when the consumer is in EX.
- Stall:
  - stall = id_valid & a used source matches a load entry with k+1 < LOAD_LAT.
  - Combinational, same cycle.
  - Re-evaluated each cycle as the load advances.
- Forward select:
  - Registered. Updated at the issue edge and valid during the consumer's EX cycle.
  - Value is k+1 of the youngest match with k+1 ≤ FWD_DEPTH, else 0.
  - Forced to 0 on a bubble edge, on unused sources, and on source x0.
  - Older writers are covered by regfile write-through.
- Redirect:
  - Acts only when id_redirect & issue.
  - flush_id = (id_redirect & issue) | (flush_cnt≠0).
  - On redirect, flush_cnt loads BRANCH_PENALTY−1; otherwise it decrements to 0.
  - The result is exactly BRANCH_PENALTY consecutive flush edges.
  - id_redirect arriving while flush_cnt≠0 is ignored: ID holds a NOP, so id_valid=0.
- Simultaneous stall and redirect: stall wins. Redirect is ignored this cycle and re-presented once the stall clears.
- Reset: all entries invalid, flush_cnt=0. Outputs after reset: stall=0, flush_id=0, fwd_sel_a=fwd_sel_b=0. Reset mid-stall or mid-flush aborts both immediately.
- rst dominates all other inputs.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - They count cycles with stall=1 and flush_id=1.
  - Saturating at 32'hFFFF_FFFF; cleared by rst.
- Undefined: the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared types package gets:
  - sb_entry_t (packed struct: valid, rd, is_load);
  - the fwd_sel encoding constant FWD_REGFILE=0.
- One sub-module, hazard_scoreboard: the parametrised shift register plus youngest-match priority encoder. It returns hit, position and is_load per source.
- Stall, forward registers and flush counter stay in hazard_unit.

Test Plan:
1. Adjacent ALU dependency, defaults: add x5 then sub x6,x5,x1, back-to-back → no stall; fwd_sel_a=1 in sub's EX cycle; fwd_sel_b=0.
2. Distance-2 dependency: add x5; nop; or x7,x1,x5 → fwd_sel_b=2; distance 3 → fwd_sel_b=0.
3. Load-use, LOAD_LAT=2: lw x7 then add x8,x7,x7 → stall=1 for exactly 1 cycle with a bubble into EX; then fwd_sel_a=fwd_sel_b=2; with LOAD_LAT=1 → no stall, fwd=1.
4. Writer to x0, or id_rd_we=0, followed by a reader of x0 → fwd_sel=0, no stall.
5. Two writers to x5 at positions 1 and 2, then a reader → fwd_sel=1 (youngest wins).
6. Redirect, BRANCH_PENALTY=2 then 3: jal in ID → flush_id high 2 (resp. 3) consecutive edges; a redirect coincident with a load-use stall is deferred until the stall clears; rst asserted mid-flush → flush_id=0 next cycle.
